// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - Active-low seven-segment glyphs for hex digits (segment order g..a).
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        for (int i = 0; i < 16; i++) begin
            if (nib == 4'(i)) seg = SEG_TABLE[i];
        end
        return seg;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - Synchronise and debounce a raw button; one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = $clog2(DB_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          stable_dly_q, stable_dly_d;
    logic          rise_q, rise_d;

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        cnt_d        = '0;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        rise_d       = stable_q & ~stable_dly_q;
        // Any cycle where the synchronised level agrees with stable restarts the count.
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            rise_q       <= rise_d;
        end
    end

    assign level      = stable_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/step_counter.sv
// rtl/step_counter.sv - Debounced push-button up/down counter with load, wrap/saturate and hex display.
module step_counter
    import seg7_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int DB_CYCLES = 1000000,
    parameter  int SATURATE  = 0,
    localparam int NDIG      = (WIDTH + 3) / 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step_btn,
    input  logic                dir,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    output logic [WIDTH-1:0]    count,
    output logic                step_pulse,
    output logic                limit,
    output logic [7*NDIG-1:0]   hex
);

    localparam int NBITS = 4 * NDIG;

    logic             btn_level;
    logic             btn_rise;
    logic             step;
    logic [WIDTH-1:0] count_q, count_d;
    logic             limit_q, limit_d;
    logic [NBITS-1:0] count_ext;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (step_btn),
        .level      (btn_level),
        .rise_pulse (btn_rise)
    );

    // The debounced level is always high while rise_pulse is; the AND keeps the step qualified by it.
    assign step = btn_rise & btn_level;

    always_comb begin
        count_d = count_q;
        limit_d = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (step) begin
            if (dir) begin
                if (count_q == '1) begin
                    limit_d = 1'b1;
                    count_d = (SATURATE != 0) ? count_q : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    limit_d = 1'b1;
                    count_d = (SATURATE != 0) ? count_q : '1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            limit_q <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end

    assign count      = count_q;
    assign limit      = limit_q;
    assign step_pulse = btn_rise;
    assign count_ext  = NBITS'(count_q);

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        assign hex[7*g +: 7] = hex_to_seg(count_ext[4*g +: 4]);
    end

endmodule

// File: tb/tb_step_counter.sv
// tb/tb_step_counter.sv - Randomised scoreboard bench for step_counter (4-bit wrap and 8-bit saturate).
module tb_step_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        step_btn = 1'b0;
    logic        dir = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  lv8 = 8'h00;
    logic [3:0]  lv4;
    logic [3:0]  cnt4;
    logic        sp4, lim4;
    logic [6:0]  hex4;
    logic [7:0]  cnt8;
    logic        sp8, lim8;
    logic [13:0] hex8;

    assign lv4 = lv8[3:0];

    step_counter #(.WIDTH(4), .DB_CYCLES(4), .SATURATE(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .step_btn(step_btn), .dir(dir), .load(load),
        .load_val(lv4), .count(cnt4), .step_pulse(sp4), .limit(lim4), .hex(hex4)
    );

    step_counter #(.WIDTH(8), .DB_CYCLES(4), .SATURATE(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .step_btn(step_btn), .dir(dir), .load(load),
        .load_val(lv8), .count(cnt8), .step_pulse(sp8), .limit(lim8), .hex(hex8)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
        bit lim;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int   pulse_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   m4 = 0, m8 = 0;
    int   s4 = 0, s8 = 0;
    bit   mon_en = 1'b0;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic int step_ref(input int c, input bit up, input int w, input bit sat,
                                    output bit lim);
        int maxv;
        maxv = (1 << w) - 1;
        lim  = 1'b0;
        if (up) begin
            if (c < maxv) return c + 1;
            lim = 1'b1;
            return sat ? c : 0;
        end
        if (c > 0) return c - 1;
        lim = 1'b1;
        return sat ? c : maxv;
    endfunction

    always @(negedge clk) begin
        bit   pe, l4, l8;
        exp_t e;
        if (mon_en) begin
            l4 = 1'b0;
            l8 = 1'b0;
            pe = (pulse_q.size() > 0) && (pulse_q[0] == cyc);
            if (pe) void'(pulse_q.pop_front());
            if (q4.size() > 0 && q4[0].cyc == cyc) begin
                e  = q4.pop_front();
                m4 = e.cnt;
                l4 = e.lim;
            end
            if (q8.size() > 0 && q8[0].cyc == cyc) begin
                e  = q8.pop_front();
                m8 = e.cnt;
                l8 = e.lim;
            end
            check("step_pulse4", 32'(sp4), 32'(pe));
            check("step_pulse8", 32'(sp8), 32'(pe));
            check("count4", 32'(cnt4), m4);
            check("count8", 32'(cnt8), m8);
            check("limit4", 32'(lim4), 32'(l4));
            check("limit8", 32'(lim8), 32'(l8));
            check("hex4", 32'(hex4), 32'(glyph_tab[m4[3:0]]));
            check("hex8", 32'(hex8), 32'({glyph_tab[m8[7:4]], glyph_tab[m8[3:0]]}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_op(input int v);
        load = 1'b1;
        lv8  = 8'(v);
        s4   = v & 15;
        s8   = v & 255;
        q4.push_back('{cyc + 1, s4, 1'b0});
        q8.push_back('{cyc + 1, s8, 1'b0});
        tick();
        load = 1'b0;
    endtask

    task automatic press(input bit d, input bit bounce, input bit coload, input bit rstmid,
                         input int lval, input int hold);
        int n;
        bit l;
        if (bounce) begin
            for (int i = 0; i < 12; i++) begin
                step_btn = ((i % 4) < 2);
                dir      = 1'($urandom);
                tick();
            end
        end
        step_btn = 1'b1;
        n = cyc;
        if (rstmid) begin
            repeat (3) tick();
            rst_n = 1'b0;
            s4 = 0;
            s8 = 0;
            q4.push_back('{cyc, 0, 1'b0});
            q8.push_back('{cyc, 0, 1'b0});
            tick();
            rst_n = 1'b1;
            n = cyc;
        end
        pulse_q.push_back(n + 7);
        while (cyc < n + 7) begin
            dir = 1'($urandom);
            tick();
        end
        dir = d;
        if (coload) begin
            load = 1'b1;
            lv8  = 8'(lval);
            s4   = lval & 15;
            s8   = lval & 255;
            q4.push_back('{n + 8, s4, 1'b0});
            q8.push_back('{n + 8, s8, 1'b0});
        end else begin
            s4 = step_ref(s4, d, 4, 1'b0, l);
            q4.push_back('{n + 8, s4, l});
            s8 = step_ref(s8, d, 8, 1'b1, l);
            q8.push_back('{n + 8, s8, l});
        end
        tick();
        load = 1'b0;
        repeat (hold) tick();
        step_btn = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        int r;
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();

        press(1'b1, 1'b0, 1'b0, 1'b0, 0, 20);
        press(1'b1, 1'b1, 1'b0, 1'b0, 0, 5);
        load_op(15);
        press(1'b1, 1'b0, 1'b0, 1'b0, 0, 3);
        press(1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
        load_op(255);
        press(1'b1, 1'b0, 1'b0, 1'b0, 0, 3);
        load_op(0);
        press(1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
        press(1'b1, 1'b0, 1'b1, 1'b0, 9, 3);
        press(1'b1, 1'b0, 1'b0, 1'b1, 0, 3);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                load_op($urandom_range(0, 255));
                repeat ($urandom_range(0, 3)) tick();
            end else begin
                press(1'($urandom), r == 2, r == 3, r == 4,
                      $urandom_range(0, 255), $urandom_range(0, 10));
            end
        end

        repeat (5) tick();
        check("pending_expectations", pulse_q.size() + q4.size() + q8.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/step_counter.md
# step_counter

Parametrised push-button step counter for the board-level demo datapath. Raw, noisy button input is synchronised and debounced on the 50 MHz system clock. Each confirmed press steps a WIDTH-bit counter up or down, in wrap or saturate mode, with synchronous load. The count drives active-low seven-segment hex digits for direct connection to the board displays.

## Interface
Parameters:
- WIDTH, 4: counter width in bits, 1..16
- DB_CYCLES, 1000000: consecutive stable clk cycles required to accept a button level change (20 ms at 50 MHz); minimum 2
- SATURATE, 0: 0 = wrap at limits, 1 = hold at limits
- NDIG, (WIDTH+3)/4: derived number of hex digits; not for override

Ports:
- clk  in  1  50 MHz system clock; sole clock in the block
- rst_n  in  1  asynchronous active-low reset
- step_btn  in  1  raw button level, asynchronous, active-high when pressed
- dir  in  1  1 = count up, 0 = count down; sampled on the step cycle
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value loaded when load = 1
- count  out  WIDTH  current count
- step_pulse  out  1  one-cycle pulse per accepted press
- limit  out  1  one-cycle pulse when a step hits a limit (wrapped or blocked)
- hex  out  7*NDIG  seven-segment digits, active-low, digit 0 in bits [6:0], segment order g..a in each digit

## Operation
- Reset (rst_n = 0, asynchronous) clears:
  - count = 0, step_pulse = 0, limit = 0, synchroniser flops = 0
  - debounce counter = 0, stable level = 0
  - every hex digit shows "0" (7'b1000000)
- Debounce:
  - step_btn passes through a 2-flop synchroniser.
  - If the synchronised level differs from the stable level, the debounce counter increments; otherwise it clears to 0.
  - When the counter reaches DB_CYCLES-1 while still differing, the stable level takes the new value and the counter clears.
  - Any bounce before that point restarts the count.
- step_pulse asserts for exactly one cycle on a 0->1 transition of the stable level. Release (1->0) generates no pulse.
- Counter update, in priority order each cycle:
  1. load = 1: count <= load_val; limit = 0. Any coincident step_pulse is discarded.
  2. step_pulse = 1, dir = 1:
     - count < 2^WIDTH-1: count + 1.
     - At max with SATURATE = 0: count <= 0, limit = 1.
     - At max with SATURATE = 1: count holds, limit = 1.
  3. step_pulse = 1, dir = 0:
     - count > 0: count - 1.
     - At 0 with SATURATE = 0: count <= 2^WIDTH-1, limit = 1.
     - At 0 with SATURATE = 1: count holds, limit = 1.
  4. Otherwise: count holds, limit = 0.
- Arithmetic is unsigned and modulo 2^WIDTH. No sign handling.
- Hex decode:
  - count is zero-extended to 4*NDIG bits and nibble n maps to digit n.
  - Values 0-9 and A-F use the standard glyphs (b and d in lower case).
  - Decode is combinational from the count register.

## Timing
- Press latency, from the step_btn edge to step_pulse: 2 cycles (synchroniser) + DB_CYCLES cycles (debounce) + 1 cycle (edge register).
- count and limit update on the clk edge after step_pulse is high, i.e. one cycle after the pulse.
- load takes effect on the next clk edge. count equals load_val from the following cycle.
- hex follows count in the same cycle. There is no extra register stage.
- limit is never high in two consecutive cycles, because steps are separated by at least DB_CYCLES cycles.
- Reset asserted mid-debounce discards the pending press. After release, a held button is accepted as a new press after the full debounce time.
- dir changing between the press and the step has no effect. Only the value of dir on the update cycle counts.

## Structure
- Package seg7_pkg:
  - hex-to-segment constant array (16 x 7 bits, active-low)
  - SEG_BLANK constant
  - function hex_to_seg(logic [3:0]) returning the segment pattern
- Sub-module btn_debounce:
  - parameter DB_CYCLES; ports clk, rst_n, btn_raw, level, rise_pulse
  - contains the synchroniser, the debounce counter ($clog2(DB_CYCLES) bits) and the edge detector
- step_counter contains:
  - one btn_debounce instance
  - the counter and limit logic
  - a generate loop of NDIG calls to hex_to_seg

## Test plan
Bench uses DB_CYCLES = 4.
- Reset then idle: count = 0, hex = 7'b1000000, step_pulse = 0 throughout.
- Clean press held for 20 cycles, WIDTH = 4, dir = 1: exactly one step_pulse, 7 cycles after the edge; count 0->1; release produces no pulse.
- Bounce: step_btn toggles every 2 cycles for 12 cycles, then holds 1: exactly one step_pulse; count increments by 1.
- Wrap, SATURATE = 0: load 15, press up -> count = 0, limit pulses once, hex = "0". Press down -> count = 15, limit pulses once, hex = 7'b0001110 ("F").
- Saturate, SATURATE = 1, WIDTH = 8: load 8'hFF, press up -> count stays 8'hFF, limit = 1, hex = {F,F}. Load 0, press down -> count stays 0, limit = 1.
- load asserted on the same cycle as step_pulse, load_val = 9: count = 9, limit = 0, no increment. rst_n pulsed low mid-debounce: the pending press is lost and count = 0.
